load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the single-cycle datapath's memory port and a fixed-latency, byte-lane data memory. Converts one load/store request (byte/half/word, signed/unsigned) into byte-enabled memory accesses. Stalls the core until the access completes and returns a sign- or zero-extended load result. Optionally detects misaligned accesses.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- MEM_LATENCY, 2: memory cycles per access; minimum 1.

- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous reset, active-high
- req_valid  in  1  datapath has a memory instruction this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  XLEN  byte address (ALU result)
- req_wdata  in  XLEN  store data (rt)
- stall  out  1  freeze PC and register-file write
- rdata  out  XLEN  extended load result
- rdata_valid  out  1  rdata valid; datapath commits this cycle
- misaligned  out  1  one-cycle pulse on a misaligned request
- mem_addr  out  XLEN  word address {req_addr[31:2],2'b00}
- mem_we  out  1  store strobe
- mem_byte_en  out  4  lane enables; lane i = byte at word address + i (little-endian)
- mem_data_in  out  4x8  byte lanes [0:3] to memory
- mem_data_out  in  4x8  byte lanes [0:3] from memory

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, req_valid=1, aligned:
  - Register address, size, unsigned flag, write flag and lane-placed write data.
  - Load counter with MEM_LATENCY-1.
  - Go to ACCESS.
  - stall=1 combinationally in this same cycle.
- ACCESS:
  - stall=1.
  - mem_addr, mem_byte_en and mem_data_in are driven from the registered request and held stable.
  - mem_we=1 throughout for stores.
  - Counter decrements each cycle. At count 0, capture mem_data_out into the load register and go to DONE.
- DONE:
  - stall=0. rdata_valid=1 for loads, 0 for stores.
  - req_valid is ignored; this is the same instruction committing.
  - Go to IDLE unconditionally.
- Store lane placement:
  - byte: data[7:0] on all lanes; byte_en = 1<<addr[1:0].
  - half: data[15:0] on lanes {1,0} and {3,2}; byte_en 0011 if addr[1]=0, else 1100.
  - word: lane i = data[8i+7:8i]; byte_en 1111.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lanes {2k+1,2k}, with k=addr[1].
  - word: lanes {3,2,1,0}.
  - Byte and half results are sign-extended unless unsigned. req_unsigned is ignored for word.
- Loads drive mem_byte_en from size/offset; mem_we=0.
- IDLE with req_valid=0: stall=0, mem_we=0, mem_byte_en=0.
- Misaligned request: half with addr[0]=1, or word/reserved with addr[1:0]≠0 (see Configuration).

## Timing
- Request presented in IDLE at cycle 0:
  - ACCESS occupies cycles 1..MEM_LATENCY.
  - DONE is cycle MEM_LATENCY+1.
  - stall is high for cycles 0..MEM_LATENCY, i.e. MEM_LATENCY+1 cycles.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. Throughput is one access per MEM_LATENCY+2 cycles.
- rdata is registered and holds its last load value until the next load's DONE.
- Reset values (asynchronous): state IDLE, counter 0, rdata 0, rdata_valid 0, misaligned 0, mem_we 0, mem_byte_en 0, mem_data_in 0.
  - stall=0 while rst_b=1.
  - Reset mid-ACCESS aborts the access, and mem_we falls immediately.
- A misaligned request is handled in its IDLE cycle:
  - misaligned=1, stall=0, no memory access, rdata_valid=0.
  - FSM stays IDLE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned requests are rejected as in Timing.
  - misaligned pulses for one cycle.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned is tied 0.
  - Half accesses use addr with bit 0 forced to 0; word accesses use addr with bits [1:0] forced to 0.
  - The access then proceeds normally.

## Test plan
- Word store/load, MEM_LATENCY=2:
  - sw 0xDEADBEEF @0x100 -> mem_byte_en=1111, mem_we high cycles 1-2, stall high cycles 0-2.
  - lw @0x100 -> rdata=0xDEADBEEF, rdata_valid in cycle 3.
- Byte loads:
  - Memory word 0x80FF7F01 @0x200, lb @0x203 -> 0xFFFFFF80.
  - lbu @0x203 -> 0x00000080.
  - lb @0x201 -> 0x0000007F.
- Half store then load:
  - sh 0x1234ABCD @0x302 -> lanes 2,3 = CD,AB; byte_en=1100.
  - lh @0x302 -> 0xFFFFABCD.
  - lhu @0x302 -> 0x0000ABCD.
- Misaligned, macro on:
  - lw @0x101 -> misaligned=1 for one cycle, stall=0, mem_byte_en=0, FSM stays IDLE.
- Misaligned, macro off:
  - lw @0x101 -> access to 0x100 proceeds; misaligned stays 0.
- Reset in ACCESS during sw -> mem_we, stall and mem_byte_en drop to 0 asynchronously.
  - After release with req_valid=0, state is IDLE.
  - A following lw completes normally with MEM_LATENCY+1 stall cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane memory accesses with stall and sign/zero-extended load return.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests instead of force-aligning them.
module load_store_unit #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  stall,
    output logic [XLEN-1:0]       rdata,
    output logic                  rdata_valid,
    output logic                  misaligned,
    output logic [XLEN-1:0]       mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_byte_en,
    output logic [0:3][7:0]       mem_data_in,
    input  logic [0:3][7:0]       mem_data_out
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LATENCY - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:2]  addr_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [0:3][7:0]  wdat_q;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic             idle, in_acc, bad, accept, ld_cap;
    logic [1:0]       off_n;
    logic [3:0]       be_n;
    logic [0:3][7:0]  wdat_n;
    logic [7:0]       lb;
    logic [15:0]      lh;

    assign idle   = (state_q == IDLE);
    assign in_acc = (state_q == ACCESS);

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = ((req_size == 2'b01) & req_addr[0]) |
                 (req_size[1] & (|req_addr[1:0]));
`else
    assign bad = 1'b0;
`endif

    assign accept = idle & req_valid & ~bad;

    // Offset is force-aligned to the access size; only matters when not trapping.
    always_comb begin
        off_n  = req_addr[1:0];
        be_n   = 4'b1111;
        wdat_n = {req_wdata[7:0], req_wdata[15:8],
                  req_wdata[23:16], req_wdata[31:24]};
        unique case (req_size)
            2'b00: begin
                be_n   = 4'b0001 << req_addr[1:0];
                wdat_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                off_n  = {req_addr[1], 1'b0};
                be_n   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdat_n = {2{req_wdata[7:0], req_wdata[15:8]}};
            end
            default: off_n = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = ACCESS;
                cnt_d   = LAT_M1;
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ld_cap = in_acc & (cnt_q == '0) & ~we_q;

    always_comb begin
        lb = mem_data_out[off_q];
        lh = {mem_data_out[{off_q[1], 1'b1}],
              mem_data_out[{off_q[1], 1'b0}]};
        unique case (size_q)
            2'b00: rdata_d = uns_q ? {{(XLEN-8){1'b0}}, lb}
                                   : {{(XLEN-8){lb[7]}}, lb};
            2'b01: rdata_d = uns_q ? {{(XLEN-16){1'b0}}, lh}
                                   : {{(XLEN-16){lh[15]}}, lh};
            default: rdata_d = {mem_data_out[3], mem_data_out[2],
                                mem_data_out[1], mem_data_out[0]};
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr[XLEN-1:2];
                off_q  <= off_n;
                size_q <= req_size;
                uns_q  <= req_unsigned;
                we_q   <= req_write;
                be_q   <= be_n;
                wdat_q <= wdat_n;
            end
            if (ld_cap) rdata_q <= rdata_d;
        end
    end

    assign stall       = ~rst_b & (accept | in_acc);
    assign misaligned  = ~rst_b & idle & req_valid & bad;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE) & ~we_q;
    assign mem_addr    = {addr_q, 2'b00};
    assign mem_we      = in_acc & we_q;
    assign mem_byte_en = in_acc ? be_q : 4'b0000;
    assign mem_data_in = wdat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane memory model and load scoreboard.
module tb_load_store_unit;

    localparam int L = 2;

    logic            clk;
    logic            rst_b;
    logic            req_valid;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            stall;
    logic [31:0]     rdata;
    logic            rdata_valid;
    logic            misaligned;
    logic [31:0]     mem_addr;
    logic            mem_we;
    logic [3:0]      mem_byte_en;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;

    logic [7:0]  mem [0:1023];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++)
            mem_data_out[i] = mem[{mem_addr[9:2], 2'(i)}];
    end

    always @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i])
                    mem[{mem_addr[9:2], 2'(i)}] <= mem_data_in[i];
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    // One request; checks stall length, strobes, lanes and (for loads) the scoreboard.
    task automatic access(input string tag, input logic w,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_ma, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd,
                          output logic [0:3][7:0] lanes);
        int st_cnt;
        int we_cnt;
        bit done;
        logic [3:0] be_seen;
        logic [31:0] ma_seen;
        logic mis_seen;
        st_cnt = 0; we_cnt = 0; done = 0;
        be_seen = 4'b0; ma_seen = '0; mis_seen = 1'b0; lanes = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        if (!w) exp_q.push_back(exp_rd);
        #1;
        if (stall) st_cnt++;
        mis_seen = misaligned;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            mis_seen = mis_seen | misaligned;
            if (mem_we) we_cnt++;
            if (mem_byte_en != 4'b0) begin
                be_seen = mem_byte_en;
                ma_seen = mem_addr;
                lanes   = mem_data_in;
            end
            if (stall) st_cnt++;
            else begin
                done = 1;
                chk({tag, "_rvalid"}, 32'(rdata_valid), 32'(!w));
                if (rdata_valid) begin
                    chk({tag, "_sbsize"}, 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0)
                        chk({tag, "_rdata"}, rdata, exp_q.pop_front());
                end
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall"}, st_cnt, L + 1);
        chk({tag, "_we"}, we_cnt, w ? L : 0);
        chk({tag, "_be"}, 32'(be_seen), 32'(exp_be));
        chk({tag, "_addr"}, ma_seen, exp_ma);
        chk({tag, "_mis"}, 32'(mis_seen), 32'd0);
    endtask

    initial begin
        logic [0:3][7:0] ln;
        rst_b = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", 32'(rdata_valid), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_byte_en), 0);
        chk("rst_din", mem_data_in, 0);
        chk("rst_mis", 32'(misaligned), 0);
        rst_b = 1'b0;

        access("sw", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 0, ln);
        chk("sw_lanes", ln, 32'hEFBEADDE);
        access("lw", 0, 2'b10, 0, 32'h100, 0, 32'h100, 4'b1111, 32'hDEADBEEF, ln);

        access("sw2", 1, 2'b10, 0, 32'h200, 32'h80FF7F01, 32'h200, 4'b1111, 0, ln);
        access("lb3", 0, 2'b00, 0, 32'h203, 0, 32'h200, 4'b1000, 32'hFFFFFF80, ln);
        access("lbu3", 0, 2'b00, 1, 32'h203, 0, 32'h200, 4'b1000, 32'h00000080, ln);
        access("lb1", 0, 2'b00, 0, 32'h201, 0, 32'h200, 4'b0010, 32'h0000007F, ln);

        access("sh", 1, 2'b01, 0, 32'h302, 32'h1234ABCD, 32'h300, 4'b1100, 0, ln);
        chk("sh_lane2", 32'(ln[2]), 32'hCD);
        chk("sh_lane3", 32'(ln[3]), 32'hAB);
        chk("sh_hold", rdata, 32'h0000007F);
        access("lh", 0, 2'b01, 0, 32'h302, 0, 32'h300, 4'b1100, 32'hFFFFABCD, ln);
        access("lhu", 0, 2'b01, 1, 32'h302, 0, 32'h300, 4'b1100, 32'h0000ABCD, ln);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h101;
        #1;
        chk("mis_pulse", 32'(misaligned), 1);
        chk("mis_stall", 32'(stall), 0);
        chk("mis_be", 32'(mem_byte_en), 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mis_off", 32'(misaligned), 0);
        chk("mis_idle_stall", 32'(stall), 0);
        chk("mis_idle_be", 32'(mem_byte_en), 0);
        chk("mis_rvalid", 32'(rdata_valid), 0);
`else
        access("lwmis", 0, 2'b10, 0, 32'h101, 0, 32'h100, 4'b1111, 32'hDEADBEEF, ln);
`endif

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h400; req_wdata = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rsta_we_pre", 32'(mem_we), 1);
        rst_b = 1'b1;
        #1;
        chk("rsta_we", 32'(mem_we), 0);
        chk("rsta_stall", 32'(stall), 0);
        chk("rsta_be", 32'(mem_byte_en), 0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rsta_idle_stall", 32'(stall), 0);
        chk("rsta_idle_rv", 32'(rdata_valid), 0);
        access("lwrst", 0, 2'b10, 0, 32'h100, 0, 32'h100, 4'b1111, 32'hDEADBEEF, ln);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
